// File: rtl/load_store_unit.sv
// load_store_unit: CPU-side load/store front end for a 512x16 data memory.
//
// Accepts one load or store per cycle over a valid/ready handshake. Stores go
// into a small in-order queue and drain to memory in any cycle the port is not
// claimed by a load. Loads see queued store data (youngest matching entry) and
// answer one cycle after acceptance.
//
// Optional build macro: LSU_BOUNDS_CHECK_EN. When it is defined, requests with
// address bits above ADDR_BITS set are accepted but not performed, and they
// return a faulting response. When it is undefined, addresses wrap and
// resp_fault stays 0.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   req_valid/we/addr/wdata, req_ready   request handshake (we=1 store)
//   resp_valid/rdata/fwd/fault           load response, 1 cycle after accept
//   flush_req, flush_done                drain-all request / completion pulse
//   stq_count                            store queue occupancy
//   mem_we/addr/wdata, mem_rdata         memory port (async read)
`default_nettype none

module load_store_unit #(
  parameter int ADDR_BITS = 9,
  parameter int STQ_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  input  logic                         req_we,
  input  logic [15:0]                  req_addr,
  input  logic [15:0]                  req_wdata,
  output logic                         req_ready,
  output logic                         resp_valid,
  output logic [15:0]                  resp_rdata,
  output logic                         resp_fwd,
  output logic                         resp_fault,
  input  logic                         flush_req,
  output logic                         flush_done,
  output logic [$clog2(STQ_DEPTH):0]   stq_count,
  output logic                         mem_we,
  output logic [15:0]                  mem_addr,
  output logic [15:0]                  mem_wdata,
  input  logic [15:0]                  mem_rdata
);
  localparam int PTR_W = $clog2(STQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [15:0]          data;
  } stq_entry_t;

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

  stq_entry_t           stq [STQ_DEPTH];
  logic [PTR_W-1:0]     head, tail;
  state_t               state, state_nxt;

  logic [ADDR_BITS-1:0] ea;
  logic                 addr_fault;
  logic                 acc, ld_acc, st_acc, flt_acc, drain;

  assign ea = req_addr[ADDR_BITS-1:0];

`ifdef LSU_BOUNDS_CHECK_EN
  assign addr_fault = |req_addr[15:ADDR_BITS];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[15:ADDR_BITS];
  assign addr_fault     = 1'b0;
`endif

  // A full queue blocks loads too; otherwise a stream of loads could starve
  // the drain forever.
  assign req_ready = rst_n && (stq_count != CNT_W'(STQ_DEPTH)) && (state != FLUSH);
  assign acc       = req_valid && req_ready;
  assign ld_acc    = acc && !req_we && !addr_fault;
  assign st_acc    = acc &&  req_we && !addr_fault;
  assign flt_acc   = acc && addr_fault;
  // Accepted loads own the memory port; any other cycle may drain the head.
  assign drain     = !ld_acc && (stq_count != '0);

  // Forwarding: lane i looks at the i-th oldest entry, so the highest
  // matching lane is the youngest store to this address.
  logic [STQ_DEPTH-1:0]       hit_age;
  logic [STQ_DEPTH-1:0][15:0] age_data;
  logic                       fwd_hit;
  logic [15:0]                fwd_data;

  for (genvar i = 0; i < STQ_DEPTH; i++) begin : g_match
    logic [PTR_W-1:0] idx;
    assign idx         = head + PTR_W'(i);
    assign hit_age[i]  = (CNT_W'(i) < stq_count) && (stq[idx].addr == ea);
    assign age_data[i] = stq[idx].data;
  end

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < STQ_DEPTH; i++) begin
      if (hit_age[i]) begin
        fwd_hit  = 1'b1;
        fwd_data = age_data[i];
      end
    end
  end

  // Queue storage needs no reset: occupancy gates every use of it.
  always_ff @(posedge clk) begin
    if (st_acc) stq[tail] <= '{addr: ea, data: req_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      stq_count <= '0;
    end else begin
      if (st_acc) tail <= tail + PTR_W'(1);
      if (drain)  head <= head + PTR_W'(1);
      case ({st_acc, drain})
        2'b10:   stq_count <= stq_count + CNT_W'(1);
        2'b01:   stq_count <= stq_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign mem_we    = drain;
  assign mem_addr  = drain ? 16'(stq[head].addr) : 16'(ea);
  assign mem_wdata = drain ? stq[head].data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fwd   <= 1'b0;
      resp_fault <= 1'b0;
    end else begin
      resp_valid <= ld_acc || flt_acc;
      resp_fault <= flt_acc;
      resp_fwd   <= ld_acc && fwd_hit;
      if (ld_acc)       resp_rdata <= fwd_hit ? fwd_data : mem_rdata;
      else if (flt_acc) resp_rdata <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    flush_done = 1'b0;
    case (state)
      IDLE:  if (flush_req) state_nxt = FLUSH;
      FLUSH: if (stq_count == '0) state_nxt = DONE;
      DONE: begin
        flush_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand sequences for flush,
// back-to-back stores and reset mid-drain, then random traffic against an
// architectural model (golden memory + pending-store FIFO).
module tb_load_store_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, flush_req = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_fwd, resp_fault, flush_done, mem_we;
  logic [15:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  stq_count;

  load_store_unit #(.ADDR_BITS(9), .STQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fwd(resp_fwd),
    .resp_fault(resp_fault), .flush_req(flush_req), .flush_done(flush_done),
    .stq_count(stq_count), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  // data_memory model plus a log of every write it receives
  logic [15:0] mem [512];
  logic [31:0] wlog [$];
  assign mem_rdata = mem[mem_addr[8:0]];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[8:0]] <= mem_wdata;
      wlog.push_back({mem_addr, mem_wdata});
    end
  end

  function automatic logic [15:0] memv(input int i);
    return 16'h5A00 ^ 16'(i);
  endfunction

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // combinational outputs sampled at the falling edge of each step
  logic        s_ready, s_we, s_fd;
  logic [15:0] s_addr, s_wdata;

  task automatic step(input logic v, input logic we, input logic [15:0] a,
                      input logic [15:0] d, input logic fl);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; flush_req = fl;
    @(negedge clk);
    s_ready = req_ready; s_we = mem_we; s_addr = mem_addr;
    s_wdata = mem_wdata; s_fd = flush_done;
    @(posedge clk); #1;
    req_valid = 1'b0; flush_req = 1'b0;
  endtask

  typedef struct {
    int          idle;
    logic        we;
    logic [15:0] addr, wdata;
    logic        exp_rv;
    logic [15:0] exp_rd;
    logic        exp_fwd, exp_flt;
    int          exp_cnt;
  } vec_t;

  vec_t        tv [10];
  logic [15:0] gmem [512];
  logic [24:0] pq [$];

  initial begin
    for (int i = 0; i < 512; i++) mem[i] <= memv(i);

    // ---- reset state ----
    #3;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_fwd", resp_fwd, 0);
    chk("rst_resp_fault", resp_fault, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_stq_count", stq_count, 0);
    chk("rst_req_ready", req_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- directed vector table ----
    tv[0] = '{0, 1'b1, 16'd10, 16'hABCD, 1'b0, 16'h0,      1'b0, 1'b0, 1};
    tv[1] = '{0, 1'b0, 16'd10, 16'h0,    1'b1, 16'hABCD,   1'b1, 1'b0, 1};
    tv[2] = '{2, 1'b0, 16'd10, 16'h0,    1'b1, 16'hABCD,   1'b0, 1'b0, 0};
    tv[3] = '{0, 1'b0, 16'd20, 16'h0,    1'b1, memv(20),   1'b0, 1'b0, 0};
    tv[4] = '{0, 1'b1, 16'd20, 16'h1111, 1'b0, 16'h0,      1'b0, 1'b0, 1};
    tv[5] = '{0, 1'b1, 16'd20, 16'h2222, 1'b0, 16'h0,      1'b0, 1'b0, 1};
    tv[6] = '{0, 1'b0, 16'd20, 16'h0,    1'b1, 16'h2222,   1'b1, 1'b0, 1};
    tv[7] = '{1, 1'b0, 16'd20, 16'h0,    1'b1, 16'h2222,   1'b0, 1'b0, 0};
`ifdef LSU_BOUNDS_CHECK_EN
    tv[8] = '{0, 1'b0, 16'h020A, 16'h0,  1'b1, 16'h0,      1'b0, 1'b1, 0};
    tv[9] = '{0, 1'b0, 16'h03FF, 16'h0,  1'b1, 16'h0,      1'b0, 1'b1, 0};
`else
    tv[8] = '{0, 1'b0, 16'h020A, 16'h0,  1'b1, 16'hABCD,   1'b0, 1'b0, 0};
    tv[9] = '{0, 1'b0, 16'h03FF, 16'h0,  1'b1, memv(511),  1'b0, 1'b0, 0};
`endif
    wlog.delete();
    for (int k = 0; k < 10; k++) begin
      repeat (tv[k].idle) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      step(1'b1, tv[k].we, tv[k].addr, tv[k].wdata, 1'b0);
      chk($sformatf("tv%0d_ready", k), s_ready, 1);
      if (!tv[k].we) begin
        chk($sformatf("tv%0d_ld_mem_we", k), s_we, 0);
        chk($sformatf("tv%0d_ld_mem_addr", k), s_addr, {7'b0, tv[k].addr[8:0]});
      end
      chk($sformatf("tv%0d_resp_valid", k), resp_valid, tv[k].exp_rv);
      if (tv[k].exp_rv) begin
        chk($sformatf("tv%0d_rdata", k), resp_rdata, tv[k].exp_rd);
        chk($sformatf("tv%0d_fwd", k), resp_fwd, tv[k].exp_fwd);
        chk($sformatf("tv%0d_fault", k), resp_fault, tv[k].exp_flt);
      end
      chk($sformatf("tv%0d_count", k), stq_count, tv[k].exp_cnt);
    end
    chk("tv_wlog_size", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("tv_wlog0", wlog[0], {16'd10, 16'hABCD});
      chk("tv_wlog1", wlog[1], {16'd20, 16'h1111});
      chk("tv_wlog2", wlog[2], {16'd20, 16'h2222});
    end

    // ---- flush with queued stores to 511 / 0x03FF ----
    begin
      int n; logic seen;
      wlog.delete();
      step(1'b1, 1'b1, 16'd511, 16'h1234, 1'b0);
      step(1'b1, 1'b1, 16'h03FF, 16'h5678, 1'b0);
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      n = 0; seen = 1'b0;
      while (!seen && n < 10) begin
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        n++;
        if (n == 1) chk("flush_ready_low", s_ready, 0);
        if (s_fd) seen = 1'b1;
      end
      chk("flush_done_seen", seen, 1);
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      chk("flush_done_one_cycle", s_fd, 0);
      chk("flush_count", stq_count, 0);
`ifdef LSU_BOUNDS_CHECK_EN
      chk("flush_wlog_size", wlog.size(), 1);
      if (wlog.size() == 1) chk("flush_wlog0", wlog[0], {16'd511, 16'h1234});
      step(1'b1, 1'b0, 16'd511, 16'h0, 1'b0);
      chk("flush_load_rdata", resp_rdata, 16'h1234);
`else
      chk("flush_wlog_size", wlog.size(), 2);
      if (wlog.size() == 2) begin
        chk("flush_wlog0", wlog[0], {16'd511, 16'h1234});
        chk("flush_wlog1", wlog[1], {16'd511, 16'h5678});
      end
      step(1'b1, 1'b0, 16'd511, 16'h0, 1'b0);
      chk("flush_load_rdata", resp_rdata, 16'h5678);
`endif
      chk("flush_load_fwd", resp_fwd, 0);
    end

    // ---- flush on an empty queue: done pulses two cycles later ----
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("eflush_c1_done", s_fd, 0);
    chk("eflush_c1_ready", s_ready, 0);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("eflush_c2_done", s_fd, 1);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("eflush_c3_done", s_fd, 0);

    // ---- five back-to-back stores ----
    begin
      int n;
      wlog.delete();
      for (int i = 0; i < 5; i++) begin
        step(1'b1, 1'b1, 16'(100 + i), 16'hB000 + 16'(i), 1'b0);
        chk($sformatf("b2b%0d_ready", i), s_ready, 1);
        chk($sformatf("b2b%0d_count", i), stq_count, 1);
      end
      n = 0;
      while (stq_count != 0 && n < 10) begin
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        n++;
      end
      chk("b2b_drained", stq_count, 0);
      chk("b2b_wlog_size", wlog.size(), 5);
      if (wlog.size() == 5)
        for (int i = 0; i < 5; i++)
          chk($sformatf("b2b_wlog%0d", i), wlog[i], {16'(100 + i), 16'hB000 + 16'(i)});
    end

    // ---- reset while a drain is on the port ----
    step(1'b1, 1'b1, 16'd200, 16'hC001, 1'b0);
    step(1'b1, 1'b1, 16'd201, 16'hC002, 1'b0);
    step(1'b1, 1'b0, 16'd201, 16'h0, 1'b0);
    @(negedge clk);
    chk("mrst_pre_mem_we", mem_we, 1);
    chk("mrst_pre_resp_valid", resp_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_mem_we", mem_we, 0);
    chk("mrst_resp_valid", resp_valid, 0);
    chk("mrst_resp_rdata", resp_rdata, 0);
    chk("mrst_resp_fwd", resp_fwd, 0);
    chk("mrst_count", stq_count, 0);
    chk("mrst_ready", req_ready, 0);
    chk("mrst_flush_done", flush_done, 0);
    @(posedge clk); #1;
    @(negedge clk) rst_n = 1'b1;
    wlog.delete();
    @(posedge clk); #1;
    repeat (5) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("mrst_no_writes", wlog.size(), 0);
    chk("mrst_count_after", stq_count, 0);

    // ---- random traffic vs architectural model ----
    for (int i = 0; i < 512; i++) gmem[i] = mem[i];
    pq.delete();
    for (int c = 0; c < 400; c++) begin
      logic v, we, flt, e_ready, acc, ld, st, e_drain, e_fwd;
      logic [8:0]  ea;
      logic [15:0] a, d, e_rd;
      v  = ($urandom_range(0, 3) != 0);
      we = 1'($urandom_range(0, 1));
      ea = 9'd300 + 9'($urandom_range(0, 7));
      a  = {7'(($urandom_range(0, 7) == 0) ? $urandom : 0), ea};
      d  = 16'($urandom);
`ifdef LSU_BOUNDS_CHECK_EN
      flt = (a[15:9] != 0);
`else
      flt = 1'b0;
`endif
      e_ready = (pq.size() < DEPTH);
      acc     = v && e_ready;
      ld      = acc && !we && !flt;
      st      = acc && we && !flt;
      e_drain = !ld && (pq.size() > 0);
      e_fwd   = 1'b0;
      foreach (pq[k]) if (pq[k][24:16] == ea) e_fwd = 1'b1;
      e_rd    = gmem[ea];

      step(v, we, a, d, 1'b0);
      chk("rnd_ready", s_ready, e_ready);
      chk("rnd_mem_we", s_we, e_drain);
      if (e_drain && pq.size() > 0) begin
        chk("rnd_drain", {s_addr, s_wdata}, {7'b0, pq[0]});
        void'(pq.pop_front());
      end
      if (ld) chk("rnd_ld_addr", s_addr, {7'b0, ea});
      if (st) begin
        pq.push_back({ea, d});
        gmem[ea] = d;
      end
      chk("rnd_resp_valid", resp_valid, ld || (acc && flt));
      if (ld) begin
        chk("rnd_rdata", resp_rdata, e_rd);
        chk("rnd_fwd", resp_fwd, e_fwd);
      end
      if (acc && flt) begin
        chk("rnd_fault", resp_fault, 1);
        chk("rnd_fault_rdata", resp_rdata, 0);
      end
      chk("rnd_count", stq_count, pq.size());
    end
    begin
      int n = 0;
      while (stq_count != 0 && n < 20) begin
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        n++;
      end
      chk("rnd_final_drain", stq_count, 0);
      for (int i = 300; i < 308; i++)
        chk($sformatf("rnd_mem%0d", i), mem[i], gmem[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
